regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Controller for the CPU's 32x32 register file write port. After reset it sequences a hardware clear of every register, one per cycle. It then shares the single write port between two writeback requesters: A (ALU path) and B (load/multi-cycle path). It uses a valid/ready handshake and round-robin fairness, and drives registered write-port signals (write, rd, input_data) into the register file.

Parameters:
DATA_W, 32, width of writeback data
ADDR_W, 5, register address width
NREG, 32, number of registers cleared by the init sequence (must equal 2**ADDR_W)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
a_valid  input  1  requester A has a writeback pending
a_rd  input  ADDR_W  requester A destination register
a_data  input  DATA_W  requester A write data
a_ready  output  1  A transfer accepted this cycle (combinational)
b_valid  input  1  requester B has a writeback pending
b_rd  input  ADDR_W  requester B destination register
b_data  input  DATA_W  requester B write data
b_ready  output  1  B transfer accepted this cycle (combinational)
rf_write  output  1  register file write enable (registered)
rf_rd  output  ADDR_W  register file write address (registered)
rf_data  output  DATA_W  register file write data (registered)
init_busy  output  1  high while the clear sequence runs (registered)

Behaviour:
- Reset (rst=1 at a clock edge):
  - state<=INIT, ptr<=0, prio<=A.
  - rf_write<=0, rf_rd<=0, rf_data<=0, init_busy<=1.
  - a_ready=b_ready=0 while state=INIT.
- Reset takes priority over every other event. If it is asserted mid-clear or mid-run:
  - the clear restarts from register 0;
  - any in-flight registered write is dropped (rf_write<=0);
  - requester data is not captured.
- INIT state:
  - Each cycle: rf_write<=1, rf_rd<=ptr, rf_data<=0, ptr<=ptr+1.
  - In the cycle ptr=NREG-1: state<=RUN and init_busy<=0 at the same edge.
  - rf_write pulses for exactly NREG consecutive cycles (addresses 0..NREG-1 in order), starting the cycle after rst deasserts.
  - a_ready and b_ready are held 0 throughout; valids are ignored.
- RUN state, grant (combinational, only in RUN):
  - Only a_valid: a_ready=1.
  - Only b_valid: b_ready=1.
  - Both valid: the requester named by prio gets ready; the other sees ready=0.
  - Neither valid: both readies 0.
  - Never both readies high in one cycle.
- Transfer: valid & ready at a clock edge. At that edge:
  - rf_rd<=granted rd, rf_data<=granted data.
  - rf_write<=1 if granted rd!=0, else 0. A register-0 write is accepted (handshake completes) but suppressed.
  - prio<=the other requester. prio updates on every transfer, contested or not.
- No transfer: rf_write<=0; rf_rd and rf_data hold their previous values.
- Latency: a transfer at edge t produces rf_write high in the cycle following t. The register file commits it at edge t+1.
- Throughput: one write per cycle, sustained.
- Ordering: when A and B target the same rd in the same cycle, the two writes are serialized in grant order. The later-granted data is the final register value.
- Requester obligation: while valid=1 and ready=0, rd and data must stay stable. The arbiter does not latch non-granted requests.
- Valid may drop without a transfer; the arbiter keeps no memory of it.
- No other states exist; RUN persists until rst.

Test Plan:
- Reset clear: hold rst 3 cycles, release -> rf_write high 32 cycles with rf_rd=0..31 and rf_data=0; init_busy falls on the same edge as the last clear; a_ready=b_ready=0 throughout even with a_valid=1.
- Single requester: in RUN, a_valid=1, a_rd=5, a_data=0xDEADBEEF for one cycle -> a_ready=1 that cycle; next cycle rf_write=1, rf_rd=5, rf_data=0xDEADBEEF; the following cycle rf_write=0.
- Contention/fairness: a_valid=b_valid=1 held 4 cycles with distinct rd (A:3, B:7) -> grants A,B,A,B; rf_rd sequence 3,7,3,7 one cycle later; readies never both high.
- Register 0 suppression: b_valid=1, b_rd=0, b_data=0x1234 -> b_ready=1, rf_write stays 0 next cycle; prio toggles, so a subsequent contested cycle grants A.
- Same-destination race: A rd=9 data=0x11 and B rd=9 data=0x22 both valid, prio=B -> writes 0x22 then 0x11 on consecutive cycles; register 9 ends as 0x11.
- Reset mid-clear: assert rst when ptr=17 -> next cycle rf_write=0, init_busy=1; after release the clear restarts at rf_rd=0 and again lasts 32 cycles.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file write port.
// The slave side is the arbiter; the master side holds the requesters and the register file.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic              init_busy;

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, rf_write, rf_rd, rf_data, init_busy
  );

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, rf_write, rf_rd, rf_data, init_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port controller: clears all registers after reset, then
// round-robin arbitrates two writeback requesters onto the single write port.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {PRIO_A, PRIO_B} prio_t;

  state_t            state;
  prio_t             prio;
  logic [ADDR_W-1:0] ptr;
  logic              rf_write_q;
  logic [ADDR_W-1:0] rf_rd_q;
  logic [DATA_W-1:0] rf_data_q;
  logic              init_busy_q;

  logic              grant_a;
  logic              grant_b;
  logic [ADDR_W-1:0] grant_rd;
  logic [DATA_W-1:0] grant_data;

  // At most one grant per cycle; prio only breaks ties when both are valid.
  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    grant_rd   = bus.a_rd;
    grant_data = bus.a_data;
    if (state == RUN) begin
      grant_a = bus.a_valid && (!bus.b_valid || prio == PRIO_A);
      grant_b = bus.b_valid && !grant_a;
    end
    if (grant_b) begin
      grant_rd   = bus.b_rd;
      grant_data = bus.b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      prio        <= PRIO_A;
      ptr         <= '0;
      rf_write_q  <= 1'b0;
      rf_rd_q     <= '0;
      rf_data_q   <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          rf_write_q <= 1'b1;
          rf_rd_q    <= ptr;
          rf_data_q  <= '0;
          ptr        <= ptr + 1'b1;
          if (ptr == ADDR_W'(NREG - 1)) begin
            state       <= RUN;
            init_busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (grant_a || grant_b) begin
            // Register 0 is hardwired: the handshake completes but no write is issued.
            rf_write_q <= (grant_rd != '0);
            rf_rd_q    <= grant_rd;
            rf_data_q  <= grant_data;
            prio       <= grant_a ? PRIO_B : PRIO_A;
          end else begin
            rf_write_q <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.rf_write  = rf_write_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_data   = rf_data_q;
  assign bus.init_busy = init_busy_q;
endmodule
